// File: rtl/game_phase_controller.sv
// Frog/car game sequencer: owns phase, lives and level, gates car movement and pulses frog reset.
// Optional build macro BONUS_LIFE_EN: each level-up also grants one life, capped at 3.
module game_phase_controller #(
    parameter int LIVES_INIT      = 3,
    parameter int MAX_LEVEL       = 9,
    parameter int DEATH_FRAMES    = 60,
    parameter int LEVELUP_FRAMES  = 90,
    parameter int GAMEOVER_FRAMES = 180,
    parameter int FLASH_FRAMES    = 8
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic [3:0] i_Switches,
    input  logic       i_Frame_Tick,
    input  logic       i_Collision,
    input  logic       i_Frog_At_Top,
    output logic [2:0] o_Phase,
    output logic [3:0] o_Level,
    output logic [1:0] o_Lives,
    output logic       o_Move_En,
    output logic       o_Reset_Frog,
    output logic       o_Flash
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        DEATH     = 3'd2,
        LEVEL_UP  = 3'd3,
        GAME_OVER = 3'd4
    } phase_t;

    // A zero frame count still needs one tick to leave the phase.
    localparam int DEATH_N    = (DEATH_FRAMES    < 1) ? 1 : DEATH_FRAMES;
    localparam int LEVELUP_N  = (LEVELUP_FRAMES  < 1) ? 1 : LEVELUP_FRAMES;
    localparam int GAMEOVER_N = (GAMEOVER_FRAMES < 1) ? 1 : GAMEOVER_FRAMES;
    localparam int FLASH_N    = (FLASH_FRAMES    < 1) ? 1 : FLASH_FRAMES;
    localparam int MAX_A      = (DEATH_N > LEVELUP_N) ? DEATH_N : LEVELUP_N;
    localparam int MAX_N      = (MAX_A > GAMEOVER_N) ? MAX_A : GAMEOVER_N;
    localparam int CW         = $clog2(MAX_N + 1);
    localparam int FW         = $clog2(FLASH_N + 1);

    localparam logic [CW-1:0] DEATH_LAST    = CW'(DEATH_N - 1);
    localparam logic [CW-1:0] LEVELUP_LAST  = CW'(LEVELUP_N - 1);
    localparam logic [CW-1:0] GAMEOVER_LAST = CW'(GAMEOVER_N - 1);
    localparam logic [FW-1:0] FLASH_LAST    = FW'(FLASH_N - 1);
    localparam logic [3:0]    LEVEL_MAX     = 4'(MAX_LEVEL);
    localparam logic [1:0]    LIVES_RST     = 2'(LIVES_INIT);

    phase_t        phase_q, phase_d;
    logic [3:0]    level_q;
    logic [1:0]    lives_q;
    logic          move_en_q;
    logic          reset_frog_q;
    logic          flash_q;
    logic [CW-1:0] frame_cnt_q;
    logic [FW-1:0] flash_cnt_q;
    logic [1:0]    guard_q;
    logic          sw_any_q;

    logic          sw_any, abort, start, hit, goal, timed, frame_last, timed_exit, enter;
    logic [3:0]    level_up;
    logic [1:0]    lives_up;

    assign sw_any = |i_Switches;
    assign abort  = (i_Switches == 4'b1111);
    assign start  = (phase_q == IDLE) && sw_any && !sw_any_q && !abort;
    assign hit    = (phase_q == PLAY) && (guard_q == 2'd0) && i_Collision;
    assign goal   = (phase_q == PLAY) && (guard_q == 2'd0) && !i_Collision && i_Frog_At_Top;
    assign timed  = (phase_q == DEATH) || (phase_q == LEVEL_UP) || (phase_q == GAME_OVER);

    assign level_up = (level_q >= LEVEL_MAX) ? level_q : level_q + 4'd1;
`ifdef BONUS_LIFE_EN
    assign lives_up = (lives_q == 2'd3) ? lives_q : lives_q + 2'd1;
`else
    assign lives_up = lives_q;
`endif

    always_comb begin
        frame_last = 1'b0;
        case (phase_q)
            DEATH:     frame_last = (frame_cnt_q == DEATH_LAST);
            LEVEL_UP:  frame_last = (frame_cnt_q == LEVELUP_LAST);
            GAME_OVER: frame_last = (frame_cnt_q == GAMEOVER_LAST);
            default:   frame_last = 1'b0;
        endcase
    end

    assign timed_exit = timed && i_Frame_Tick && frame_last;

    always_comb begin
        phase_d = phase_q;
        enter   = 1'b0;
        if (abort) begin
            phase_d = IDLE;
            enter   = 1'b1;
        end else begin
            case (phase_q)
                IDLE: if (start) begin
                    phase_d = PLAY;
                    enter   = 1'b1;
                end
                PLAY: if (hit) begin
                    phase_d = (lives_q <= 2'd1) ? GAME_OVER : DEATH;
                    enter   = 1'b1;
                end else if (goal) begin
                    phase_d = LEVEL_UP;
                    enter   = 1'b1;
                end
                DEATH, LEVEL_UP: if (timed_exit) begin
                    phase_d = PLAY;
                    enter   = 1'b1;
                end
                GAME_OVER: if (timed_exit) begin
                    phase_d = IDLE;
                    enter   = 1'b1;
                end
                default: begin
                    phase_d = IDLE;
                    enter   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            phase_q      <= IDLE;
            level_q      <= 4'd1;
            lives_q      <= LIVES_RST;
            move_en_q    <= 1'b0;
            reset_frog_q <= 1'b0;
            flash_q      <= 1'b0;
            frame_cnt_q  <= '0;
            flash_cnt_q  <= '0;
            guard_q      <= 2'd0;
            sw_any_q     <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            move_en_q    <= (phase_d == PLAY);
            reset_frog_q <= enter && (phase_d == PLAY);
            sw_any_q     <= sw_any;

            if (enter) begin
                frame_cnt_q <= '0;
                flash_cnt_q <= '0;
                flash_q     <= 1'b0;
                // Guard spans the reset-pulse cycle plus one more.
                guard_q     <= (phase_d == PLAY) ? 2'd2 : 2'd0;
            end else begin
                if (guard_q != 2'd0) guard_q <= guard_q - 2'd1;
                if (timed && i_Frame_Tick) begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                    if (flash_cnt_q == FLASH_LAST) begin
                        flash_cnt_q <= '0;
                        flash_q     <= ~flash_q;
                    end else begin
                        flash_cnt_q <= flash_cnt_q + 1'b1;
                    end
                end
            end

            if (abort || start) begin
                level_q <= 4'd1;
                lives_q <= LIVES_RST;
            end else if (hit) begin
                lives_q <= lives_q - 2'd1;
            end else if ((phase_q == LEVEL_UP) && timed_exit) begin
                level_q <= level_up;
                lives_q <= lives_up;
            end
        end
    end

    assign o_Phase      = phase_q;
    assign o_Level      = level_q;
    assign o_Lives      = lives_q;
    assign o_Move_En    = move_en_q;
    assign o_Reset_Frog = reset_frog_q;
    assign o_Flash      = flash_q;

endmodule

// File: tb/tb_game_phase_controller.sv
// Bench for game_phase_controller: directed scenarios then random play against a rule-level model.
module tb_game_phase_controller;

    localparam int LIVES_INIT = 3;
    localparam int MAX_LEVEL  = 3;
    localparam int DEATH_F    = 4;
    localparam int LEVELUP_F  = 3;
    localparam int GAMEOVER_F = 5;
    localparam int FLASH_F    = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       tick, col, top;
    logic [2:0] o_phase;
    logic [3:0] o_level;
    logic [1:0] o_lives;
    logic       o_move_en, o_reset_frog, o_flash;

    always #5 clk = ~clk;

    game_phase_controller #(
        .LIVES_INIT(LIVES_INIT), .MAX_LEVEL(MAX_LEVEL), .DEATH_FRAMES(DEATH_F),
        .LEVELUP_FRAMES(LEVELUP_F), .GAMEOVER_FRAMES(GAMEOVER_F), .FLASH_FRAMES(FLASH_F)
    ) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Switches(sw), .i_Frame_Tick(tick),
        .i_Collision(col), .i_Frog_At_Top(top), .o_Phase(o_phase), .o_Level(o_level),
        .o_Lives(o_lives), .o_Move_En(o_move_en), .o_Reset_Frog(o_reset_frog), .o_Flash(o_flash)
    );

    int checks = 0;
    int errors = 0;

    // Model state: phase number, ticks seen and cycles spent in the current phase.
    int m_phase, m_level, m_lives, m_ticks, m_age, m_pulse;
    bit m_prev_any;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_phase = 0; m_level = 1; m_lives = LIVES_INIT;
        m_ticks = 0; m_age = 0; m_pulse = 0; m_prev_any = 1'b0;
    endtask

    task automatic m_enter(input int ph);
        m_phase = ph; m_ticks = 0; m_age = 0; m_pulse = (ph == 1) ? 1 : 0;
    endtask

    function automatic int frames_of(input int ph);
        case (ph)
            2:       return DEATH_F;
            3:       return LEVELUP_F;
            default: return GAMEOVER_F;
        endcase
    endfunction

    task automatic m_step(input logic [3:0] s, input bit t, input bit c, input bit a);
        bit rise;
        rise = (s != 4'd0) && !m_prev_any;
        m_prev_any = (s != 4'd0);
        m_pulse = 0;
        if (s == 4'hF) begin
            m_enter(0); m_level = 1; m_lives = LIVES_INIT;
        end else if (m_phase == 0) begin
            if (rise) begin m_enter(1); m_level = 1; m_lives = LIVES_INIT; end
        end else if (m_phase == 1) begin
            if (m_age >= 2 && c) begin
                m_lives = m_lives - 1;
                m_enter(m_lives == 0 ? 4 : 2);
            end else if (m_age >= 2 && a) begin
                m_enter(3);
            end else begin
                m_age++;
            end
        end else if (t) begin
            m_ticks++;
            if (m_ticks >= frames_of(m_phase)) begin
                if (m_phase == 3) begin
                    m_level = (m_level + 1 > MAX_LEVEL) ? MAX_LEVEL : m_level + 1;
`ifdef BONUS_LIFE_EN
                    m_lives = (m_lives + 1 > 3) ? 3 : m_lives + 1;
`endif
                end
                m_enter(m_phase == 4 ? 0 : 1);
            end
        end
    endtask

    task automatic compare_all();
        int exp_flash;
        exp_flash = (m_phase >= 2) ? ((m_ticks / FLASH_F) % 2) : 0;
        chk("phase", o_phase, m_phase);
        chk("level", o_level, m_level);
        chk("lives", o_lives, m_lives);
        chk("move_en", o_move_en, (m_phase == 1) ? 1 : 0);
        chk("reset_frog", o_reset_frog, m_pulse);
        chk("flash", o_flash, exp_flash);
    endtask

    task automatic cycle(input logic [3:0] s, input bit t, input bit c, input bit a);
        sw = s; tick = t; col = c; top = a;
        @(posedge clk);
        m_step(s, t, c, a);
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cycle(4'd0, 1'b1, 1'b0, 1'b0);
            cycle(4'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic reset_outputs_check(input string tag);
        chk({tag, "_phase"}, o_phase, 0);
        chk({tag, "_level"}, o_level, 1);
        chk({tag, "_lives"}, o_lives, LIVES_INIT);
        chk({tag, "_move"}, o_move_en, 0);
        chk({tag, "_frog"}, o_reset_frog, 0);
        chk({tag, "_flash"}, o_flash, 0);
    endtask

    initial begin
        int exp_lvl[3];
        exp_lvl[0] = 2; exp_lvl[1] = 3; exp_lvl[2] = 3;
        rst_n = 1'b0; sw = 4'd0; tick = 1'b0; col = 1'b0; top = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 reset_outputs_check("rst");
        @(negedge clk) rst_n = 1'b1;
        #1;

        // 1: start from IDLE
        cycle(4'b0001, 1'b0, 1'b0, 1'b0);
        chk("t1_phase", o_phase, 1);
        chk("t1_frog", o_reset_frog, 1);
        cycle(4'd0, 1'b0, 1'b0, 1'b0);
        chk("t1_frog_low", o_reset_frog, 0);

        // 2: held collision, death timing, guard after respawn
        repeat (10) cycle(4'd0, 1'b0, 1'b1, 1'b0);
        chk("t2_lives", o_lives, 2);
        chk("t2_phase", o_phase, 2);
        ticks(1);
        cycle(4'd0, 1'b1, 1'b0, 1'b0);
        chk("t2_flash", o_flash, 1);
        ticks(1);
        cycle(4'd0, 1'b1, 1'b0, 1'b0);
        chk("t2_replay", o_phase, 1);
        chk("t2_replay_frog", o_reset_frog, 1);
        repeat (3) cycle(4'd0, 1'b0, 1'b1, 1'b0);
        chk("t2_guard_lives", o_lives, 1);
        ticks(DEATH_F);

        // 3: level-ups with saturation
        for (int i = 0; i < 3; i++) begin
            repeat (2) cycle(4'd0, 1'b0, 1'b0, 1'b0);
            cycle(4'd0, 1'b0, 1'b0, 1'b1);
            chk("t3_lvlup_phase", o_phase, 3);
            ticks(LEVELUP_F);
            chk("t3_level", o_level, exp_lvl[i]);
        end

        // 4: simultaneous collision and goal until game over
        for (int i = 0; i < 4; i++) begin
            repeat (2) cycle(4'd0, 1'b0, 1'b0, 1'b0);
            cycle(4'd0, 1'b0, 1'b1, 1'b1);
            if (o_phase == 3'd4) break;
            ticks(DEATH_F);
        end
        chk("t4_phase", o_phase, 4);
        chk("t4_lives", o_lives, 0);
        ticks(GAMEOVER_F);
        chk("t4_idle", o_phase, 0);
        chk("t4_level_held", o_level, 3);

        // 5: abort during DEATH
        cycle(4'b0010, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(4'd0, 1'b0, 1'b0, 1'b0);
        cycle(4'd0, 1'b0, 1'b1, 1'b0);
        ticks(1);
        cycle(4'hF, 1'b0, 1'b0, 1'b0);
        chk("t5_phase", o_phase, 0);
        chk("t5_level", o_level, 1);
        chk("t5_lives", o_lives, 3);
        chk("t5_move", o_move_en, 0);
        cycle(4'd0, 1'b0, 1'b0, 1'b0);

        // 6: asynchronous reset mid LEVEL_UP
        cycle(4'b0100, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(4'd0, 1'b0, 1'b0, 1'b0);
        cycle(4'd0, 1'b0, 1'b0, 1'b1);
        cycle(4'd0, 1'b1, 1'b0, 1'b0);
        chk("t6_in_lvlup", o_phase, 3);
        #2 rst_n = 1'b0;
        #1 reset_outputs_check("t6_async");
        m_reset();
        sw = 4'd0; tick = 1'b0; col = 1'b0; top = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        #1;
        repeat (3) cycle(4'd0, 1'b0, 1'b0, 1'b0);

        // Random play
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [3:0] s;
            r = $urandom_range(0, 99);
            if (r < 2)       s = 4'hF;
            else if (r < 12) s = 4'($urandom_range(1, 14));
            else             s = 4'd0;
            cycle(s, ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 14) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
